// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side checker for the 3-stage PRBS (s[n] = s[n-1] ^ s[n-3], period 7,
// pattern 1110100). It self-synchronises to the incoming stream, declares lock
// after LOCK_CNT consecutive correct predictions, then counts bit errors against
// a free-running local reference. Lock is dropped after UNLOCK_ERR consecutive
// mismatches.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bit_in     received serial bit, sampled only when bit_valid=1
//   bit_valid  one-cycle strobe qualifying bit_in
//   clear      synchronous clear of err_count/bit_count (lock unaffected)
//   locked     high while locked
//   err_pulse  one-cycle pulse per mismatch while locked
//   err_count  saturating mismatch count while locked
//   bit_count  saturating count of valid bits checked while locked
module prbs_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_CNT);
  localparam logic [3:0]       MISS_TGT = 4'(UNLOCK_ERR);

  state_t           state, state_n;
  logic [2:0]       hist, hist_n;      // hist[0] is the newest bit
  logic [1:0]       fill, fill_n;      // history fill level, 3 = full
  logic [7:0]       match_cnt, match_n;
  logic [3:0]       miss_cnt, miss_n;
  logic             pulse_n;
  logic [CNT_W-1:0] err_n, bits_n;
  logic             pred, mism;

  assign pred = hist[0] ^ hist[2];
  assign mism = (bit_in != pred);

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    pulse_n = 1'b0;
    err_n   = err_count;
    bits_n  = bit_count;
    if (bit_valid) begin
      if (state == SEARCH) begin
        hist_n = {hist[1:0], bit_in};
        if (fill != 2'd3) begin
          fill_n = fill + 2'd1;
        end else if (!mism && hist != 3'b000) begin
          // All-zero history predicts zero forever; never let it build lock.
          match_n = match_cnt + 8'd1;
          if (match_n == LOCK_TGT) begin
            state_n = LOCKED;
            miss_n  = '0;
          end
        end else begin
          match_n = '0;
        end
      end else begin
        // Reference free-runs on its own prediction so a flipped input bit
        // cannot corrupt the history and cause follow-on errors.
        hist_n = {hist[1:0], pred};
        if (bit_count != CNT_MAX) bits_n = bit_count + CNT_ONE;
        if (mism) begin
          pulse_n = 1'b1;
          if (err_count != CNT_MAX) err_n = err_count + CNT_ONE;
          miss_n = miss_cnt + 4'd1;
          if (miss_n == MISS_TGT) begin
            state_n = SEARCH;
            fill_n  = '0;
            match_n = '0;
          end
        end else begin
          miss_n = '0;
        end
      end
    end
    // clear wins over a same-cycle increment; err_pulse is left alone
    if (clear) begin
      err_n  = '0;
      bits_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= pulse_n;
      err_count <= err_n;
      bit_count <= bits_n;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker (CNT_W=4 so saturation is reachable quickly).
// A vector table of {inputs, expected outputs} is built up front and applied in
// a loop; each applied record's expectation goes through a scoreboard queue and
// is compared one cycle after the sampling edge. Reset and the all-zero stream
// are hand-written sequences.
module tb_prbs_checker;

  localparam int CW = 4;

  typedef struct {
    logic          valid;
    logic          bin;
    logic          clr;
    logic          e_lock;
    logic          e_pulse;
    logic [CW-1:0] e_err;
    logic [CW-1:0] e_bits;
  } vec_t;

  logic          clk, rst, bit_in, bit_valid, clear;
  logic          locked, err_pulse;
  logic [CW-1:0] err_count, bit_count;

  prbs_checker #(.LOCK_CNT(8), .UNLOCK_ERR(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t          vecs[$];
  vec_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            pos = 0;
  logic [CW-1:0] e_err = '0;
  logic [CW-1:0] e_bits = '0;
  logic          cur_lock = 1'b0;

  function automatic logic prbs(input int p);
    logic [6:0] pat;
    pat = 7'b1110100;
    return pat[6 - (p % 7)];
  endfunction

  task automatic check(input string name, input int idx, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, idx, got, want);
    end
  endtask

  // One valid bit (optionally flipped / with clear) followed by 3 idle cycles.
  // counting: the bit is sampled while locked; lock_after: locked after it.
  task automatic add(input bit flip, input bit clr, input bit counting, input bit lock_after);
    vec_t v;
    v.valid   = 1'b1;
    v.bin     = prbs(pos) ^ flip;
    pos++;
    v.clr     = clr;
    v.e_pulse = counting & flip;
    if (clr) begin
      e_err  = '0;
      e_bits = '0;
    end else if (counting) begin
      if (e_bits != 4'd15) e_bits = e_bits + 4'd1;
      if (flip && e_err != 4'd15) e_err = e_err + 4'd1;
    end
    cur_lock = lock_after;
    v.e_lock = cur_lock;
    v.e_err  = e_err;
    v.e_bits = e_bits;
    vecs.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v.valid   = 1'b0;
      v.clr     = 1'b0;
      v.bin     = 1'($urandom_range(0, 1));
      v.e_pulse = 1'b0;
      vecs.push_back(v);
    end
  endtask

  task automatic add_idle_clear();
    vec_t v;
    e_err  = '0;
    e_bits = '0;
    v.valid = 1'b0; v.bin = 1'b1; v.clr = 1'b1;
    v.e_lock = cur_lock; v.e_pulse = 1'b0; v.e_err = '0; v.e_bits = '0;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string name, input int idx);
    vec_t e;
    @(negedge clk);
    bit_valid = v.valid;
    bit_in    = v.bin;
    clear     = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    clear     = 1'b0;
    e = exp_q.pop_front();
    check({name, ".locked"},    idx, int'(locked),    int'(e.e_lock));
    check({name, ".err_pulse"}, idx, int'(err_pulse), int'(e.e_pulse));
    check({name, ".err_count"}, idx, int'(err_count), int'(e.e_err));
    check({name, ".bit_count"}, idx, int'(bit_count), int'(e.e_bits));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t z;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;

    // clean lock: locked after valid bit 11, bits counted from bit 12
    for (int k = 1; k <= 20; k++) add(1'b0, 1'b0, k > 11, k >= 11);
    // single error, then clean bits run bit_count into saturation
    add(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) add(1'b0, 1'b0, 1'b1, 1'b1);
    // clear on an idle cycle keeps lock
    add_idle_clear();
    // loss of lock on 3rd consecutive error, then relock after 11 valid bits
    add(1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 11; k++) add(1'b0, 1'b0, 1'b0, k == 11);
    // a good bit between error pairs resets the miss run
    add(1'b1, 1'b0, 1'b1, 1'b1); add(1'b1, 1'b0, 1'b1, 1'b1); add(1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1); add(1'b1, 1'b0, 1'b1, 1'b1); add(1'b0, 1'b0, 1'b1, 1'b1);
    // 20 spaced errors: err_count saturates at 15
    for (int k = 0; k < 20; k++) begin
      add(1'b1, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1);
    end
    // clear with a same-cycle error: counters 0, pulse still fires
    add(1'b1, 1'b1, 1'b1, 1'b1);
    // build err_count up to 5 for the reset test
    for (int k = 0; k < 5; k++) begin
      add(1'b1, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1);
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst0.locked",    0, int'(locked),    0);
    check("rst0.err_pulse", 0, int'(err_pulse), 0);
    check("rst0.err_count", 0, int'(err_count), 0);
    check("rst0.bit_count", 0, int'(bit_count), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

    // async reset mid-lock with err_count=5, checked before the next edge
    check("pre_rst.err_count", 0, int'(err_count), 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.locked",    0, int'(locked),    0);
    check("arst.err_pulse", 0, int'(err_pulse), 0);
    check("arst.err_count", 0, int'(err_count), 0);
    check("arst.bit_count", 0, int'(bit_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // all-zero stream never locks
    z.bin = 1'b0; z.clr = 1'b0; z.e_lock = 1'b0; z.e_pulse = 1'b0;
    z.e_err = '0; z.e_bits = '0;
    for (int k = 0; k < 100; k++) begin
      z.valid = 1'b1;
      apply(z, "zero", k);
      z.valid = 1'b0;
      apply(z, "zero_idle", k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receive-side checker for the 3-stage PRBS pattern produced by the team's LFSR generator (recurrence s[n] = s[n-1] XOR s[n-3], period 7, time-ordered pattern 1110100 from seed 111). The block self-synchronises to an incoming bit stream, declares lock, then counts bit errors against a locally regenerated reference. It sits after the slow-clock serial source and drives the board LEDs and status readout.

## Interface
- LOCK_CNT, 8: consecutive correct predictions in SEARCH required to lock (1..255).
- UNLOCK_ERR, 3: consecutive mismatches in LOCKED that drop lock (1..15).
- CNT_W, 16: width of err_count and bit_count.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  received serial bit; sampled only when bit_valid=1.
- bit_valid  in  1  one-cycle strobe qualifying bit_in; gaps of any length are allowed.
- clear  in  1  synchronous clear of err_count and bit_count; lock state is unaffected.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  CNT_W  mismatches while locked, saturating at all-ones.
- bit_count  out  CNT_W  valid bits checked while locked, saturating at all-ones.

## Operation
- State: hist[2:0] (hist[0] = newest), fill counter 0..3, match counter, miss counter, FSM {SEARCH, LOCKED}.
- Prediction: pred = hist[0] XOR hist[2]. Evaluated only on valid bits.
- SEARCH:
  - Every valid bit shifts into hist (hist <= {hist[1:0], bit_in}).
  - The first 3 valid bits after reset or unlock only fill hist; no comparison is made.
  - Once full: bit_in == pred and hist != 000 increments the match counter. Otherwise the match counter clears to 0.
  - Match counter reaching LOCK_CNT transitions to LOCKED and clears the miss counter.
- LOCKED:
  - hist shifts in pred, not bit_in (free-running reference), so one flipped bit yields exactly one error.
  - bit_count increments on every valid bit.
  - On mismatch: err_pulse asserts, err_count increments, miss counter increments.
  - On match: miss counter clears.
  - Miss counter reaching UNLOCK_ERR: go to SEARCH, clear fill and match counters.
- Zero lockup: all-zero history never contributes to lock. LOCKED history cannot reach 000.
- Counters saturate at 2^CNT_W-1 with no wrap.
- clear has priority over increment in the same cycle: the counter becomes 0. err_pulse still fires.
- rst (any time, including mid-lock) puts the block in SEARCH with hist, all counters and all outputs at 0.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, bit_count=0.
- All outputs are registered. Response appears the cycle after the clock edge that samples the valid bit.
- locked rises on the cycle after the LOCK_CNT-th match. With a clean stream this is after valid bit 3+LOCK_CNT.
- locked falls on the cycle after the UNLOCK_ERR-th consecutive mismatch. That mismatch still pulses err_pulse and is counted.
- err_pulse is high for exactly one cycle per erroneous valid bit. It is never asserted in SEARCH.
- bit_valid=0 cycles change no state. err_pulse is 0 on those cycles.

## Test plan
- Reset: assert rst mid-stream while locked with err_count=5 -> locked, err_pulse, err_count and bit_count all 0 asynchronously, before the next clock edge.
- Clean lock: repeat 1110100 with bit_valid every 4th cycle, defaults -> locked rises after valid bit 11; err_count stays 0; bit_count = valid bits received since lock.
- Single error: once locked, invert one bit -> exactly one err_pulse, err_count=1, locked stays 1, subsequent bits count no errors.
- Loss of lock: invert 3 consecutive valid bits -> err_count=3, locked falls after the 3rd; a clean stream then relocks after 11 more valid bits.
- Zero stream: 100 valid bits of 0 -> locked never asserts; err_count=0.
- Clear/saturation: CNT_W=4, locked, inject 20 spaced errors -> err_count holds at 15. Assert clear on the same cycle as an error -> err_count=0 and err_pulse=1.
